// File: rtl/ifu.sv
// Instruction fetch unit: generates the PC, issues word fetches over req/gnt/rvalid,
// and buffers returned words in order for the if_id register. A jump flushes everything in flight.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        inst_valid_o,
    input  logic        id_ready_i
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   PW        = AW + 1;
    localparam logic [PW:0]   DEPTH_OCC = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    logic [31:0]    pc_q;
    logic [PW-1:0]  alloc_q;
    logic [PW-1:0]  fill_q;
    logic [PW-1:0]  read_q;
    logic [PW-1:0]  discard_cnt;
    logic [DEPTH-1:0] filled_q;
    logic [31:0]    buf_addr [DEPTH];
    logic [31:0]    buf_data [DEPTH];

    logic [AW-1:0]  alloc_idx;
    logic [AW-1:0]  fill_idx;
    logic [AW-1:0]  read_idx;
    logic [PW-1:0]  used;
    logic [PW:0]    occupancy;
    logic           grant;
    logic           rsp_drop;
    logic           rsp_fill;
    logic           pop;
    logic [PW-1:0]  jump_discard;

    assign alloc_idx = alloc_q[AW-1:0];
    assign fill_idx  = fill_q[AW-1:0];
    assign read_idx  = read_q[AW-1:0];

    // Slots still owed a response after a flush count against capacity, so a
    // stale response can never land in an entry that has been reallocated.
    assign used      = alloc_q - read_q;
    assign occupancy = {1'b0, used} + {1'b0, discard_cnt};

    assign imem_req_o  = !jump_i && (occupancy < DEPTH_OCC);
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign rsp_drop = imem_rvalid_i && (discard_cnt != '0);
    assign rsp_fill = imem_rvalid_i && (discard_cnt == '0);

    assign inst_valid_o = filled_q[read_idx] && (read_q != alloc_q) && !jump_i;
    assign inst_o       = inst_valid_o ? buf_data[read_idx] : NOP;
    assign instaddr_o   = inst_valid_o ? buf_addr[read_idx] : 32'h0;
    assign pop          = inst_valid_o && id_ready_i;

    // Everything granted but not yet returned is dropped, including a response arriving now.
    assign jump_discard = (alloc_q - fill_q) + discard_cnt
                        - (imem_rvalid_i ? PTR_ONE : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= RESET_PC;
            alloc_q     <= '0;
            fill_q      <= '0;
            read_q      <= '0;
            discard_cnt <= '0;
            filled_q    <= '0;
        end else if (jump_i) begin
            pc_q        <= jump_addr_i & 32'hFFFF_FFFC;
            alloc_q     <= read_q;
            fill_q      <= read_q;
            filled_q    <= '0;
            discard_cnt <= jump_discard;
        end else begin
            if (grant) begin
                pc_q                <= pc_q + 32'd4;
                alloc_q             <= alloc_q + PTR_ONE;
                filled_q[alloc_idx] <= 1'b0;
            end
            if (rsp_drop) begin
                discard_cnt <= discard_cnt - PTR_ONE;
            end
            if (rsp_fill) begin
                fill_q             <= fill_q + PTR_ONE;
                filled_q[fill_idx] <= 1'b1;
            end
            if (pop) begin
                read_q <= read_q + PTR_ONE;
            end
        end
    end

    // Payload storage carries no reset; the filled bits gate every use of it.
    always_ff @(posedge clk) begin
        if (grant) begin
            buf_addr[alloc_idx] <= pc_q;
        end
        if (rsp_fill && !jump_i) begin
            buf_data[fill_idx] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a queue-based instruction memory model answers grants in order,
// and each step checks the fetch and decode-side outputs against hand-derived values.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        inst_valid_o;
    logic        id_ready_i;

    logic [31:0] pend_q [$];
    logic        gnt_en;
    logic        rsp_en;
    int          grants;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .instaddr_o   (instaddr_o),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Called at the falling edge: present this cycle's memory inputs, let outputs settle.
    task automatic drive_mem();
        imem_gnt_i    = gnt_en;
        imem_rvalid_i = rsp_en && (pend_q.size() > 0);
        imem_rdata_i  = imem_rvalid_i ? word_at(pend_q[0]) : 32'h0;
        #1;
    endtask

    task automatic finish_cycle();
        logic        s_grant;
        logic        s_rv;
        logic [31:0] s_addr;
        s_grant = imem_req_o && imem_gnt_i;
        s_addr  = imem_addr_o;
        s_rv    = imem_rvalid_i;
        @(posedge clk);
        if (s_rv) void'(pend_q.pop_front());
        if (s_grant) begin
            pend_q.push_back(s_addr);
            grants++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        id_ready_i  = 1'b0;
        gnt_en      = 1'b0;
        rsp_en      = 1'b0;
        pend_q.delete();
        repeat (2) begin
            drive_mem();
            finish_cycle();
        end
        rstn = 1'b1;
    endtask

    initial begin
        rstn          = 1'b0;
        jump_i        = 1'b0;
        jump_addr_i   = 32'h0;
        id_ready_i    = 1'b0;
        gnt_en        = 1'b0;
        rsp_en        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        grants        = 0;

        @(negedge clk);
        drive_mem();
        chk1("rst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_instaddr", instaddr_o, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);

        // Streaming: one grant and one instruction per cycle, two-cycle latency.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_mem();
            chk1("s1_req", imem_req_o, 1'b1);
            chk("s1_addr", imem_addr_o, 32'(4 * i));
            if (i >= 2) begin
                chk1("s1_valid", inst_valid_o, 1'b1);
                chk("s1_instaddr", instaddr_o, 32'(4 * (i - 2)));
                chk("s1_inst", inst_o, word_at(32'(4 * (i - 2))));
            end else begin
                chk1("s1_valid_lat", inst_valid_o, 1'b0);
            end
            finish_cycle();
        end

        // Backpressure from the start: four grants fill the buffer, then requests stop.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b0; grants = 0;
        for (int i = 0; i < 8; i++) begin
            drive_mem();
            if (i >= 4) chk1("s2_req_off", imem_req_o, 1'b0);
            if (i >= 2) begin
                chk1("s2_hold_valid", inst_valid_o, 1'b1);
                chk("s2_hold_inst", inst_o, word_at(32'h0));
            end
            finish_cycle();
        end
        chk("s2_grants", 32'(grants), 32'd4);
        id_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_mem();
            if (i == 0) chk1("s2_full_noreq", imem_req_o, 1'b0);
            chk1("s2_valid", inst_valid_o, 1'b1);
            chk("s2_instaddr", instaddr_o, 32'(4 * i));
            chk("s2_inst", inst_o, word_at(32'(4 * i)));
            finish_cycle();
        end

        // Grant withheld: the fetch address must hold.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
        repeat (2) begin
            drive_mem();
            finish_cycle();
        end
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_mem();
            chk1("s3_req", imem_req_o, 1'b1);
            chk("s3_addr_hold", imem_addr_o, 32'h8);
            if (i == 1) chk("s3_instaddr", instaddr_o, 32'h4);
            if (i == 2) chk1("s3_drained", inst_valid_o, 1'b0);
            finish_cycle();
        end
        gnt_en = 1'b1;
        drive_mem();
        chk("s3_addr_regrant", imem_addr_o, 32'h8);
        finish_cycle();
        drive_mem();
        chk("s3_addr_next", imem_addr_o, 32'hC);
        finish_cycle();
        drive_mem();
        chk1("s3_valid", inst_valid_o, 1'b1);
        chk("s3_instaddr8", instaddr_o, 32'h8);
        chk("s3_inst8", inst_o, word_at(32'h8));
        finish_cycle();

        // Jump with two responses outstanding.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b0; id_ready_i = 1'b1;
        repeat (2) begin
            drive_mem();
            finish_cycle();
        end
        jump_i = 1'b1; jump_addr_i = 32'h100;
        drive_mem();
        chk1("s4_jump_noreq", imem_req_o, 1'b0);
        chk1("s4_jump_novalid", inst_valid_o, 1'b0);
        finish_cycle();
        jump_i = 1'b0; rsp_en = 1'b1;
        drive_mem();
        chk1("s4_req", imem_req_o, 1'b1);
        chk("s4_addr", imem_addr_o, 32'h100);
        chk1("s4_drop0", inst_valid_o, 1'b0);
        finish_cycle();
        drive_mem();
        chk("s4_addr2", imem_addr_o, 32'h104);
        chk1("s4_drop1", inst_valid_o, 1'b0);
        finish_cycle();
        drive_mem();
        chk1("s4_nobypass", inst_valid_o, 1'b0);
        finish_cycle();
        drive_mem();
        chk1("s4_valid", inst_valid_o, 1'b1);
        chk("s4_instaddr", instaddr_o, 32'h100);
        chk("s4_inst", inst_o, word_at(32'h100));
        finish_cycle();

        // Jump near the top of the address space: misaligned target, then PC wrap.
        jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFE;
        drive_mem();
        finish_cycle();
        jump_i = 1'b0;
        drive_mem();
        chk1("s4w_req", imem_req_o, 1'b1);
        chk("s4w_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        finish_cycle();
        drive_mem();
        chk("s4w_addr_wrap", imem_addr_o, 32'h0);
        finish_cycle();

        // Jump coinciding with a response; one more still outstanding.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b0; id_ready_i = 1'b1;
        repeat (2) begin
            drive_mem();
            finish_cycle();
        end
        jump_i = 1'b1; jump_addr_i = 32'h103; rsp_en = 1'b1;
        drive_mem();
        chk1("s5_jump_noreq", imem_req_o, 1'b0);
        finish_cycle();
        jump_i = 1'b0;
        drive_mem();
        chk1("s5_req", imem_req_o, 1'b1);
        chk("s5_addr", imem_addr_o, 32'h100);
        chk1("s5_drop", inst_valid_o, 1'b0);
        finish_cycle();
        drive_mem();
        chk1("s5_fill", inst_valid_o, 1'b0);
        finish_cycle();
        drive_mem();
        chk1("s5_valid", inst_valid_o, 1'b1);
        chk("s5_instaddr", instaddr_o, 32'h100);
        chk("s5_inst", inst_o, word_at(32'h100));
        finish_cycle();

        // Asynchronous reset with instructions buffered.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b0;
        repeat (4) begin
            drive_mem();
            finish_cycle();
        end
        drive_mem();
        chk1("s6_pre_valid", inst_valid_o, 1'b1);
        chk("s6_pre_inst", inst_o, word_at(32'h0));
        #2;
        rstn = 1'b0; gnt_en = 1'b0; rsp_en = 1'b0;
        pend_q.delete();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        #1;
        chk1("s6_rst_valid", inst_valid_o, 1'b0);
        chk("s6_rst_inst", inst_o, 32'h0000_0013);
        chk("s6_rst_instaddr", instaddr_o, 32'h0);
        chk("s6_rst_addr", imem_addr_o, 32'h0);
        @(negedge clk);
        rstn = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
        drive_mem();
        chk1("s6_req", imem_req_o, 1'b1);
        chk("s6_addr0", imem_addr_o, 32'h0);
        finish_cycle();
        drive_mem();
        chk("s6_addr4", imem_addr_o, 32'h4);
        finish_cycle();
        drive_mem();
        chk1("s6_valid", inst_valid_o, 1'b1);
        chk("s6_instaddr", instaddr_o, 32'h0);
        chk("s6_inst", inst_o, word_at(32'h0));
        finish_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: the producer side of the fetch/decode interface. It generates the PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in order. It presents `{inst, instaddr}` pairs with valid/ready to the if_id register that feeds `id`. A `jump_i` redirect from ex flushes all fetched and in-flight instructions and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: buffer entries; power of 2, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `jump_i`  in  1  redirect request from ex.
- `jump_addr_i`  in  32  redirect target.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address; word aligned.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response valid; responses return in grant order.
- `imem_rdata_i`  in  32  response instruction word.
- `inst_o`  out  32  instruction to if_id.
- `instaddr_o`  out  32  PC of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` and `instaddr_o` are valid.
- `id_ready_i`  in  1  downstream accepts the instruction this cycle.

## Operation
- State:
  - `pc_q`.
  - DEPTH-entry circular buffer; each entry holds addr, data and a filled bit.
  - Three pointers: alloc, fill and read, each log2(DEPTH)+1 bits wide with a wrap bit.
  - `discard_cnt`, 0..DEPTH.
- Reset values:
  - `pc_q` = RESET_PC.
  - All pointers = 0, all filled bits = 0, `discard_cnt` = 0.
  - `inst_valid_o` = 0, `inst_o` = 32'h0000_0013 (NOP), `instaddr_o` = 0.
- Issue:
  - `imem_req_o` = !jump_i && (allocated entries + `discard_cnt`) < DEPTH.
  - `imem_addr_o` = `pc_q`.
  - On req && gnt: write `pc_q` into the entry at alloc, clear its filled bit, increment alloc, and set `pc_q` += 4 (32-bit wrap; 0xFFFF_FFFC → 0).
  - Without gnt, `imem_addr_o` holds stable.
- Response:
  - On rvalid with `discard_cnt` > 0: decrement `discard_cnt`, drop the data.
  - Otherwise: write `imem_rdata_i` into the entry at fill, set its filled bit, increment fill.
- Output:
  - `inst_valid_o` = entry at read is filled && read != alloc && !jump_i.
  - `inst_o` and `instaddr_o` come from the entry at read. When `inst_valid_o` = 0, `inst_o` = NOP and `instaddr_o` = 0.
  - On valid && ready: increment read.
- Redirect (`jump_i` = 1):
  - `pc_q` ← {jump_addr_i[31:2], 2'b00}.
  - alloc, fill and read all ← read's value; all filled bits cleared.
  - `discard_cnt` ← (alloc − fill) − (rvalid && `discard_cnt` == 0 ? 1 : 0) + (`discard_cnt` − (rvalid && `discard_cnt` > 0 ? 1 : 0)). That is, every response not yet returned is discarded, including one arriving this cycle.
  - No pop and no grant occur in the jump cycle; `imem_req_o` is 0.
- Simultaneous events:
  - Pop and grant in the same cycle at full: grant is not offered; the pop frees the slot for the next cycle.
  - Fill and grant in the same cycle: independent.
  - Fill of the read entry: visible next cycle; no bypass.
  - A jump held for several cycles keeps requests blocked and re-applies the target each cycle.
- Protocol assumption: `imem_rvalid_i` never precedes its grant; the earliest response is the cycle after gnt.
- Reset mid-operation: all state clears asynchronously. The instruction memory shares `rstn`, so no stale responses follow reset.

## Timing
- First `imem_req_o` occurs in the first cycle with `rstn` = 1.
- Latency: grant in cycle N, rvalid in N+1, `inst_valid_o` in N+2 (two cycles minimum).
- Throughput: one instruction per cycle with 1-cycle memory and DEPTH ≥ 3. DEPTH = 2 gives 2 per 3 cycles.
- Redirect: `jump_i` in cycle J; request for the target in J+1; earliest target instruction valid in J+3 (zero-wait memory).
- Backpressure: `inst_o` and `instaddr_o` hold stable while valid && !ready. Requests cease once allocated entries reach DEPTH.

## Test plan
- Reset release with gnt = 1, rvalid 1 cycle after, ready = 1 -> addresses 0x0, 0x4, 0x8, … on consecutive cycles; first `inst_valid_o` two cycles after the first grant; thereafter one instruction per cycle with matching `instaddr_o`.
- `id_ready_i` = 0 from the start -> exactly 4 grants, then `imem_req_o` = 0; `inst_o` frozen at the word from 0x0; ready = 1 resumes in order 0x0, 0x4, 0x8, 0xC, 0x10.
- `imem_gnt_i` = 0 for 3 cycles -> `imem_addr_o` holds 0x8 for all 3 cycles; `pc_q` advances only on gnt.
- Jump to 0x100 with 2 responses outstanding -> `imem_req_o` = 0 in the jump cycle; both stale responses dropped; next valid output has `instaddr_o` = 0x100.
- Jump to 0x103 in the same cycle as an rvalid -> that response is discarded; fetch address 0x100.
- Assert `rstn` low mid-stream with 3 buffered instructions -> all outputs reset immediately (`inst_valid_o` = 0, `inst_o` = 0x13); fetch restarts at RESET_PC.
